// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU: opcode encoding, FSM states and
// small decode helpers used by the core and its ALU.
package cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LDA = 4'h2,
    OP_STA = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_JN  = 4'hB,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_ARG = 3'd1,
    EXEC      = 3'd2,
    MEM_RD    = 3'd3,
    MEM_WR    = 3'd4,
    HALT      = 3'd5
  } state_t;

  // States in which the core owns an outstanding bus request.
  function automatic logic is_bus_state(input state_t s);
    return (s == FETCH_OP) || (s == FETCH_ARG) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

  // Opcodes whose ACC result depends on a memory read of the operand address.
  function automatic logic is_mem_read_op(input logic [OPC_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: produces the next ACC value for an opcode
// together with the zero/negative flags of that value.
module acc_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; an incomplete always_comb would infer a latch.
  always_comb begin
    result = acc;
    case (opcode)
      OP_LDI, OP_LDA: result = operand;
      OP_ADD:         result = acc + operand;
      OP_SUB:         result = acc - operand;
      OP_AND:         result = acc & operand;
      OP_OR:          result = acc | operand;
      OP_XOR:         result = acc ^ operand;
      default:        result = acc;
    endcase
    z = (result == '0);
    n = result[DATA_W-1];
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: two-word instructions fetched over a req/ack bus with
// wait states, registered Z/N flags, terminal HALT and debug visibility.
module acc_cpu_core
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic              zflag,
  output logic              nflag,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [DATA_W-1:0] dbg_acc,
  output logic [2:0]        dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [OPC_W-1:0]  ir_op_q;
  logic [DATA_W-1:0] ir_opd_q;
  logic [DATA_W-1:0] acc_q;
  logic              zflag_q, nflag_q;

  logic              ir_op_we, ir_opd_we, pc_inc, pc_jump, acc_we;
  logic [DATA_W-1:0] alu_operand, alu_result;
  logic              alu_z, alu_n;
  logic [ADDR_W-1:0] opd_addr;

  // Operand word is truncated (or zero-extended) to the address space.
  assign opd_addr = ADDR_W'(ir_opd_q);

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode  (ir_op_q),
    .acc     (acc_q),
    .operand (alu_operand),
    .result  (alu_result),
    .z       (alu_z),
    .n       (alu_n)
  );

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register is cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH_OP;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ir_op_we    = 1'b0;
    ir_opd_we   = 1'b0;
    pc_inc      = 1'b0;
    pc_jump     = 1'b0;
    acc_we      = 1'b0;
    alu_operand = ir_opd_q;
    case (state_q)
      FETCH_OP: begin
        if (mem_ack) begin
          ir_op_we = 1'b1;
          pc_inc   = 1'b1;
          state_d  = FETCH_ARG;
        end
      end
      FETCH_ARG: begin
        if (mem_ack) begin
          ir_opd_we = 1'b1;
          pc_inc    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH_OP;
        if (is_mem_read_op(ir_op_q)) begin
          state_d = MEM_RD;
        end else begin
          case (ir_op_q)
            OP_LDI:  acc_we  = 1'b1;
            OP_STA:  state_d = MEM_WR;
            OP_JMP:  pc_jump = 1'b1;
            OP_JZ:   pc_jump = zflag_q;
            OP_JN:   pc_jump = nflag_q;
            OP_HLT:  state_d = HALT;
            default: state_d = FETCH_OP;
          endcase
        end
      end
      MEM_RD: begin
        alu_operand = mem_rdata;
        if (mem_ack) begin
          acc_we  = 1'b1;
          state_d = FETCH_OP;
        end
      end
      MEM_WR: begin
        if (mem_ack) state_d = FETCH_OP;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      ir_op_q  <= '0;
      ir_opd_q <= '0;
      acc_q    <= '0;
      zflag_q  <= 1'b0;
      nflag_q  <= 1'b0;
    end else begin
      if (ir_op_we)  ir_op_q  <= mem_rdata[OPC_W-1:0];
      if (ir_opd_we) ir_opd_q <= mem_rdata;
      if (pc_jump)     pc_q <= opd_addr;
      else if (pc_inc) pc_q <= pc_q + ADDR_W'(1);
      // Flags always track the value just written into ACC.
      if (acc_we) begin
        acc_q   <= alu_result;
        zflag_q <= alu_z;
        nflag_q <= alu_n;
      end
    end
  end

  // Request is masked by reset so an in-flight access is abandoned at once.
  assign mem_req   = rst && is_bus_state(state_q);
  assign mem_we    = rst && (state_q == MEM_WR);
  assign mem_addr  = ((state_q == MEM_RD) || (state_q == MEM_WR)) ? opd_addr : pc_q;
  assign mem_wdata = acc_q;

  assign halted    = (state_q == HALT);
  assign zflag     = zflag_q;
  assign nflag     = nflag_q;
  assign dbg_pc    = pc_q;
  assign dbg_acc   = acc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench: an instruction-level reference model predicts every bus
// transaction and the final architectural state; monitors compare on ack.
module tb_acc_cpu_core;
  import cpu_pkg::*;

  typedef struct {
    int          addr;
    bit          we;
    logic [15:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter core (8-bit data, 8-bit address).
  logic       rst;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       halted, zflag, nflag;
  logic [7:0] dbg_pc, dbg_acc;
  logic [2:0] dbg_state;
  logic [7:0] mem [256];

  // Wide core with a tiny address space for wrap-around checks.
  logic        rst_w;
  logic        w_req, w_we, w_ack;
  logic [3:0]  w_addr, w_pc;
  logic [15:0] w_wdata, w_rdata, w_acc;
  logic        w_halted, w_z, w_n;
  logic [2:0]  w_state;
  logic [15:0] mem_w [16];

  acc_cpu_core dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .halted(halted),
    .zflag(zflag), .nflag(nflag), .dbg_pc(dbg_pc), .dbg_acc(dbg_acc), .dbg_state(dbg_state)
  );

  acc_cpu_core #(.DATA_W(16), .ADDR_W(4), .RESET_PC(4'd14)) dut_w (
    .clk(clk), .rst(rst_w), .mem_req(w_req), .mem_we(w_we), .mem_addr(w_addr),
    .mem_wdata(w_wdata), .mem_ack(w_ack), .mem_rdata(w_rdata), .halted(w_halted),
    .zflag(w_z), .nflag(w_n), .dbg_pc(w_pc), .dbg_acc(w_acc), .dbg_state(w_state)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  txn_t exp_q[$];
  txn_t exp_w_q[$];
  bit   rand_wait = 0, stall_writes = 0, ack_in_reset = 1;

  logic [15:0] ref_mem [256];
  logic [15:0] m_acc;
  int          m_pc;
  bit          m_z, m_n, m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input bit wide, input int a, input bit we, input logic [15:0] d);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = d;
    if (wide) exp_w_q.push_back(t);
    else      exp_q.push_back(t);
  endfunction

  // Instruction-level interpreter over ref_mem; emits the expected bus trace.
  task automatic model(input bit wide, input int dw, input int aw, input int pc0);
    int          amask = (1 << aw) - 1;
    logic [15:0] dmask = 16'((1 << dw) - 1);
    m_pc = pc0; m_acc = '0; m_z = 0; m_n = 0; m_halt = 0;
    for (int k = 0; k < 300 && !m_halt; k++) begin
      int          op, a;
      logic [15:0] opd, v, r;
      push(wide, m_pc, 0, 0);
      op   = int'(ref_mem[m_pc] & 16'h000F);
      m_pc = (m_pc + 1) & amask;
      push(wide, m_pc, 0, 0);
      opd  = ref_mem[m_pc] & dmask;
      m_pc = (m_pc + 1) & amask;
      a    = int'(opd) & amask;
      r    = m_acc;
      case (op)
        1: r = opd;
        2, 4, 5, 6, 7, 8: begin
          push(wide, a, 0, 0);
          v = ref_mem[a] & dmask;
          case (op)
            2:       r = v;
            4:       r = m_acc + v;
            5:       r = m_acc - v;
            6:       r = m_acc & v;
            7:       r = m_acc | v;
            default: r = m_acc ^ v;
          endcase
        end
        3: begin
          push(wide, a, 1, m_acc);
          ref_mem[a] = m_acc;
        end
        9:  m_pc = a;
        10: if (m_z) m_pc = a;
        11: if (m_n) m_pc = a;
        15: m_halt = 1;
        default: ;
      endcase
      if (op == 1 || op == 2 || (op >= 4 && op <= 8)) begin
        m_acc = r & dmask;
        m_z   = (m_acc == 0);
        m_n   = m_acc[dw-1];
      end
    end
  endtask

  // Bus responder for the 8-bit core: random 0-3 wait states per access.
  int waits = 0;
  bit busy = 0;
  always @(negedge clk) begin
    if (!rst) begin
      mem_ack = ack_in_reset;
      busy    = 0;
    end else if (!mem_req) begin
      mem_ack = 0;
      busy    = 0;
    end else begin
      if (!busy) begin
        busy  = 1;
        waits = rand_wait ? $urandom_range(0, 3) : 0;
      end
      if (mem_we && stall_writes) begin
        mem_ack = 0;
      end else if (waits == 0) begin
        mem_ack = 1;
        busy    = 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata     = mem[mem_addr];
      end else begin
        mem_ack = 0;
        waits--;
      end
    end
  end

  // Zero-wait responder for the wide core.
  always @(negedge clk) begin
    w_ack = rst_w && w_req;
    if (w_ack) begin
      if (w_we) mem_w[w_addr] = w_wdata;
      else      w_rdata       = mem_w[w_addr];
    end
  end

  // Monitor for the 8-bit core: trace comparison plus request stability.
  initial begin
    txn_t       t;
    bit         hv = 0;
    logic [7:0] ha, hd;
    logic       hw;
    forever begin
      @(negedge clk); #1;
      if (!rst || !mem_req) begin
        hv = 0;
      end else begin
        if (hv) begin
          check("addr stable while waiting", mem_addr, ha);
          check("we stable while waiting", mem_we, hw);
          check("wdata stable while waiting", mem_wdata, hd);
        end
        if (mem_ack) begin
          hv = 0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected bus access: addr 0x%0h we %0b, expected none", mem_addr, mem_we);
          end else begin
            t = exp_q.pop_front();
            check("bus addr", mem_addr, t.addr);
            check("bus we", mem_we, t.we);
            if (t.we) check("bus wdata", mem_wdata, t.wdata);
          end
        end else begin
          hv = 1; ha = mem_addr; hw = mem_we; hd = mem_wdata;
        end
      end
    end
  end

  // Monitor for the wide core.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk); #1;
      if (rst_w && w_req && w_ack) begin
        if (exp_w_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected wide bus access: addr 0x%0h, expected none", w_addr);
        end else begin
          t = exp_w_q.pop_front();
          check("wide bus addr", w_addr, t.addr);
          check("wide bus we", w_we, t.we);
          if (t.we) check("wide bus wdata", w_wdata, t.wdata);
        end
      end
    end
  end

  // Loads the model from mem, releases reset, runs to HALT and checks state.
  task automatic run_prog(input bit waits_on, input int watch_pc, input int exp_cycles);
    bit seen = 0;
    int cyc  = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = {8'h00, mem[i]};
    model(0, 8, 8, 0);
    rand_wait = waits_on;
    @(posedge clk); #2 rst = 1; #1;
    check("first req after reset", mem_req, 1);
    check("first addr after reset", mem_addr, 0);
    check("first we after reset", mem_we, 0);
    while (!halted && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      if (watch_pc >= 0 && !seen && dbg_pc == watch_pc[7:0]) begin
        seen = 1;
        check("nflag at jump target", nflag, 1);
      end
    end
    check("halted", halted, 1);
    if (exp_cycles > 0) check("cycles to halt", cyc, exp_cycles);
    repeat (4) @(posedge clk);
    #1;
    check("pending bus accesses", exp_q.size(), 0);
    check("final acc", dbg_acc, m_acc);
    check("final pc", dbg_pc, m_pc);
    check("final zflag", zflag, m_z);
    check("final nflag", nflag, m_n);
    check("final state", dbg_state, HALT);
    @(negedge clk); rst = 0;
  endtask

  task automatic load_prog_a();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h05;   // LDI 5
    mem[2] = 8'h04; mem[3] = 8'h20;   // ADD [0x20]
    mem[4] = 8'h03; mem[5] = 8'h21;   // STA 0x21
    mem[6] = 8'h0F; mem[7] = 8'h00;   // HLT
    mem[8'h20] = 8'h03;
  endtask

  task automatic load_random_prog();
    int n_ins = 12;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < n_ins; k++) begin
      int op, opd;
      op = (k == n_ins - 1) ? 15 : $urandom_range(0, 14);
      if (op == 2 || (op >= 3 && op <= 8)) opd = $urandom_range(128, 255);
      else if (op >= 9 && op <= 11)         opd = 2 * $urandom_range(k + 1, n_ins - 1);
      else                                  opd = $urandom_range(0, 255);
      mem[2*k]   = {4'($urandom), 4'(op)};
      mem[2*k+1] = 8'(opd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst = 0; rst_w = 0; mem_ack = 0; mem_rdata = '0; w_ack = 0; w_rdata = '0;

    // Reset held with mem_ack high: the bus must stay quiet.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset dbg_pc", dbg_pc, 0);
    check("reset dbg_acc", dbg_acc, 0);
    check("reset halted", halted, 0);
    check("reset zflag", zflag, 0);
    check("reset nflag", nflag, 0);
    check("reset state", dbg_state, FETCH_OP);
    ack_in_reset = 0;

    // Reference program, zero-wait, then with random wait states.
    load_prog_a();
    run_prog(0, -1, 14);
    check("prog A M[0x21] zero-wait", mem[8'h21], 8'h08);
    load_prog_a();
    run_prog(1, -1, 0);
    check("prog A M[0x21] with waits", mem[8'h21], 8'h08);

    // Conditional jumps on N then Z.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h80;   // LDI 0x80
    mem[8'h02] = 8'h0B; mem[8'h03] = 8'h10;   // JN 0x10
    mem[8'h04] = 8'h01; mem[8'h05] = 8'h01;   // LDI 1 (skipped)
    mem[8'h06] = 8'h0F;                       // HLT (skipped)
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h00;   // LDI 0
    mem[8'h12] = 8'h0A; mem[8'h13] = 8'h30;   // JZ 0x30
    mem[8'h14] = 8'h0F;                       // HLT (skipped)
    mem[8'h30] = 8'h0F;                       // HLT
    run_prog(1, 16, 0);
    check("jump program zflag", zflag, 1);
    check("jump program pc", dbg_pc, 8'h32);

    // Random straight-line programs with forward jumps and random waits.
    for (int r = 0; r < 6; r++) begin
      load_random_prog();
      run_prog(1, -1, 0);
    end

    // Reset asserted while a store is stalled in a wait state.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h55;   // LDI 0x55
    mem[2] = 8'h03; mem[3] = 8'h40;   // STA 0x40
    mem[4] = 8'h0F;                   // HLT
    mem[8'h40] = 8'hA5;
    exp_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = {8'h00, mem[i]};
    model(0, 8, 8, 0);
    stall_writes = 1; rand_wait = 1;
    @(posedge clk); #2 rst = 1;
    cyc = 0;
    while (dbg_state != MEM_WR && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("store reaches MEM_WR", dbg_state, MEM_WR);
    repeat (2) @(posedge clk);
    #3;
    check("stalled store req", mem_req, 1);
    check("stalled store we", mem_we, 1);
    rst = 0; #1;
    check("req drops with reset", mem_req, 0);
    check("we drops with reset", mem_we, 0);
    check("state after mid-store reset", dbg_state, FETCH_OP);
    stall_writes = 0;
    repeat (2) @(posedge clk);
    mem[0] = 8'h00; mem[1] = 8'h00;   // NOP
    mem[2] = 8'h0F; mem[3] = 8'h00;   // HLT
    run_prog(1, -1, 0);
    check("abandoned store never lands", mem[8'h40], 8'hA5);

    // Wide core: PC wrap from 15 to 0 and 16-bit modular add.
    for (int i = 0; i < 16; i++) mem_w[i] = 16'h0000;
    mem_w[14] = 16'h0000; mem_w[15] = 16'h1234;   // NOP
    mem_w[0]  = 16'h0001; mem_w[1]  = 16'hFFFF;   // LDI 0xFFFF
    mem_w[2]  = 16'h0004; mem_w[3]  = 16'h0008;   // ADD [8]
    mem_w[4]  = 16'h000F; mem_w[5]  = 16'h0000;   // HLT
    mem_w[8]  = 16'h0002;
    for (int i = 0; i < 256; i++) ref_mem[i] = (i < 16) ? mem_w[i] : 16'h0000;
    exp_w_q.delete();
    model(1, 16, 4, 14);
    @(posedge clk); #2 rst_w = 1; #1;
    check("wide first req", w_req, 1);
    check("wide first addr", w_addr, 14);
    cyc = 0;
    while (!w_halted && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("wide halted", w_halted, 1);
    repeat (3) @(posedge clk);
    #1;
    check("wide pending bus accesses", exp_w_q.size(), 0);
    check("wide ACC 0xFFFF+2", w_acc, 16'h0001);
    check("wide final acc", w_acc, m_acc);
    check("wide final pc", w_pc, m_pc);
    check("wide zflag", w_z, m_z);
    check("wide nflag", w_n, m_n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
